// File: rtl/branch_seq_if.sv
// Interface bundling every signal between branch_seq and its neighbours.
// Macro: none.
//   stream in   : cfg_start, in_valid, in_ready, in_data, flush
//   branch bus  : ld_data, rst_data, ld_weight, sel, in_branch, prod
//   stream out  : out_valid, out_ready, out_data
//   status      : busy
// Modports:
//   master : environment view (front-end stream source, branch datapath, result sink)
//   slave  : sequencer view (used by branch_seq)
interface branch_seq_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 4 * WIDTH + 3
);
    logic                   cfg_start;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   flush;
    logic [4:0]             ld_data;
    logic [4:0]             rst_data;
    logic [4:0]             ld_weight;
    logic [2:0]             sel;
    logic [WIDTH-1:0]       in_branch;
    logic [4*WIDTH-1:0]     prod;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_data;
    logic                   busy;

    modport master (
        output cfg_start, in_valid, in_data, flush, prod, out_ready,
        input  in_ready, ld_data, rst_data, ld_weight, sel, in_branch,
               out_valid, out_data, busy
    );

    modport slave (
        input  cfg_start, in_valid, in_data, flush, prod, out_ready,
        output in_ready, ld_data, rst_data, ld_weight, sel, in_branch,
               out_valid, out_data, busy
    );
endinterface

// File: rtl/branch_seq.sv
// Sequencer for one conv1d branch datapath. Loads five weights after
// cfg_start, then repeatedly loads non-overlapping five-sample windows,
// steps the tap select over the window accumulating branch products and
// emits one dot product per window.
// Optional feature macro: BRANCH_SEQ_FLUSH_EN (flush computes a partial window).
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : branch_seq_if.slave
//            in stream  (cfg_start, in_valid/in_ready/in_data, flush)
//            branch bus (ld_data, rst_data, ld_weight, sel, in_branch, prod)
//            out stream (out_valid/out_ready/out_data), busy
module branch_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 4 * WIDTH + 3
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_seq_if.slave  bus
);

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned PROD_W   = 4 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(4);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_W   = 3'd1,
        CLR    = 3'd2,
        WAIT_D = 3'd3,
        MAC    = 3'd4,
        OUT    = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_nxt;
    logic                   accept;
    logic                   out_take;
    logic [PROD_W-1:0]      prod_in;

    // Handshakes are derived from state directly so next-state never reads an output.
    assign accept   = bus.in_valid && ((state == LD_W) || (state == WAIT_D));
    assign out_take = bus.out_ready && (state == OUT);
    assign prod_in  = bus.prod;

    // State, tap counter and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    // Next-state, counter and accumulator update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        case (state)
            IDLE: begin
                if (bus.cfg_start) begin
                    state_nxt = LD_W;
                    cnt_nxt   = '0;
                end
            end
            LD_W: begin
                if (accept) begin
                    if (cnt == LAST_TAP) begin
                        state_nxt = CLR;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            CLR: begin
                cnt_nxt   = '0;
                acc_nxt   = '0;
                state_nxt = WAIT_D;
            end
            WAIT_D: begin
                // A data handshake wins over cfg_start and flush in the same cycle.
                if (accept) begin
                    if (cnt == LAST_TAP) begin
                        state_nxt = MAC;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (bus.cfg_start && (cnt == '0)) begin
                    state_nxt = LD_W;
                    cnt_nxt   = '0;
                end
`ifdef BRANCH_SEQ_FLUSH_EN
                // Unloaded data regs are zero from CLR, so MAC yields the partial sum.
                else if (bus.flush && (cnt != '0)) begin
                    state_nxt = MAC;
                    cnt_nxt   = '0;
                end
`endif
            end
            MAC: begin
                acc_nxt = acc + ACC_WIDTH'(prod_in);
                if (cnt == LAST_TAP) begin
                    state_nxt = OUT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            OUT: begin
                if (out_take) begin
                    state_nxt = CLR;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                acc_nxt   = '0;
            end
        endcase
    end

    // Output decode; register strobes fire only in the handshake cycle.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.ld_weight = '0;
        bus.ld_data   = '0;
        bus.rst_data  = '0;
        bus.sel       = '0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            LD_W: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (bus.in_valid) begin
                    bus.ld_weight = 5'd1 << cnt;
                end
            end
            CLR: begin
                bus.rst_data = 5'b11111;
                bus.busy     = 1'b1;
            end
            WAIT_D: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ld_data = 5'd1 << cnt;
                end
            end
            MAC: begin
                bus.sel  = cnt;
                bus.busy = 1'b1;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    // Result is the accumulator register itself; it only changes in CLR and MAC.
    assign bus.out_data  = acc;
    // Branch registers take samples straight from the input stream.
    assign bus.in_branch = bus.in_data;

endmodule
